// File: rtl/apb_bridge_ctrl_if.sv
// Bus bundle for apb_bridge_ctrl: AHB-side transfer signals plus the APB master bus.
// slave = the bridge's view; master = the environment (AHB requester and APB responders).
interface apb_bridge_ctrl_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_SLV = 3
);
   logic               valid;
   logic               hreadyin;
   logic               hwrite;
   logic [ADDR_W-1:0]  haddr;
   logic [DATA_W-1:0]  hwdata;
   logic               hreadyout;
   logic               hresp;
   logic [DATA_W-1:0]  hrdata;
   logic [DATA_W-1:0]  prdata;
   logic               pready;
   logic               pslverr;
   logic [NUM_SLV-1:0] psel;
   logic               penable;
   logic               pwrite;
   logic [ADDR_W-1:0]  paddr;
   logic [DATA_W-1:0]  pwdata;

   modport slave (
      input  valid, hreadyin, hwrite, haddr, hwdata, prdata, pready, pslverr,
      output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );

   modport master (
      output valid, hreadyin, hwrite, haddr, hwdata, prdata, pready, pslverr,
      input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller with tag-decoded slave select and two-cycle AHB error response.
// Optional APB_TIMEOUT_EN adds a wait-state limit that turns a stalled access into an error.
module apb_bridge_ctrl #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_SLV  = 3,
   parameter logic [7:0]  BASE_TAG = 8'h81,
   parameter int unsigned TIMEOUT  = 16
) (
   input logic              hclk,
   input logic              hreset,
   apb_bridge_ctrl_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StWwait, StSetup, StAccess, StErr1, StErr2} state_e;

   state_e             state_q, acc_state;
   logic [NUM_SLV-1:0] slv_q, psel_q, dec_sel;
   logic               penable_q, pwrite_q, hresp_q;
   logic [ADDR_W-1:0]  paddr_q;
   logic [DATA_W-1:0]  pwdata_q;
   logic [7:0]         tag;
   logic               dec_hit, hreadyout, accept, timeout;

   assign tag = bus.haddr[ADDR_W-1 -: 8];

   always_comb begin
      dec_sel = '0;
      dec_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if ({24'd0, tag} == 32'(BASE_TAG) + i) begin
            dec_sel[i] = 1'b1;
            dec_hit    = 1'b1;
         end
      end
      acc_state = !dec_hit ? StErr1 : (bus.hwrite ? StWwait : StSetup);
   end

   always_comb begin
      case (state_q)
         StIdle, StErr2: hreadyout = 1'b1;
         StAccess:       hreadyout = bus.pready & ~bus.pslverr;
         default:        hreadyout = 1'b0;
      endcase
   end

   assign accept = bus.valid & bus.hreadyin & hreadyout;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CntW-1:0] wait_cnt_q;
   // Fires in the TIMEOUT-th consecutive stalled ACCESS cycle.
   assign timeout = (wait_cnt_q == CntW'(TIMEOUT - 1)) & ~bus.pready;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q   <= StIdle;
         slv_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         hresp_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         case (state_q)
            StWwait: begin
               pwdata_q <= bus.hwdata;
               psel_q   <= slv_q;
               state_q  <= StSetup;
            end
            StSetup: begin
               penable_q <= 1'b1;
               state_q   <= StAccess;
`ifdef APB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            StAccess: begin
               if (bus.pready || timeout) begin
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  if (bus.pslverr || timeout) begin
                     state_q <= StErr1;
                     hresp_q <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            StErr1: state_q <= StErr2;
            StErr2: begin
               state_q <= StIdle;
               hresp_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase

         // A new address phase overrides the completion path (back-to-back).
         if (accept) begin
            state_q <= acc_state;
            hresp_q <= ~dec_hit;
            if (dec_hit) begin
               paddr_q  <= bus.haddr;
               pwrite_q <= bus.hwrite;
               slv_q    <= dec_sel;
               psel_q   <= bus.hwrite ? '0 : dec_sel;
            end
         end
      end
   end

   assign bus.hreadyout = hreadyout;
   assign bus.hresp     = hresp_q;
   assign bus.hrdata    = (state_q == StAccess && !pwrite_q) ? bus.prdata : '0;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Self-checking bench for apb_bridge_ctrl: directed scenarios plus randomized transfers
// checked against a transaction-level model of decode, latency and response.
module tb_apb_bridge_ctrl;
   localparam int         AW   = 32;
   localparam int         DW   = 32;
   localparam int         NS   = 3;
   localparam logic [7:0] BASE = 8'h81;
   localparam int         TO   = 16;

   logic hclk, hreset;
   apb_bridge_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus_if ();

   apb_bridge_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .BASE_TAG(BASE), .TIMEOUT(TO)
   ) dut (
      .hclk  (hclk),
      .hreset(hreset),
      .bus   (bus_if)
   );

   int checks = 0;
   int errors = 0;

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   // APB responder: inserts slv_waits wait states, then completes with slv_err.
   int              slv_waits = 0;
   logic            slv_err = 1'b0;
   logic [DW-1:0]   slv_rdata = '0;
   int              acc_cycles = 0;
   always @(negedge hclk) begin
      if (bus_if.psel != '0 && bus_if.penable) begin
         bus_if.pready  = (acc_cycles >= slv_waits);
         bus_if.pslverr = bus_if.pready & slv_err;
         acc_cycles++;
      end else begin
         bus_if.pready  = 1'b0;
         bus_if.pslverr = 1'b0;
         acc_cycles     = 0;
      end
      bus_if.prdata = slv_rdata;
   end

   // Observations of the current transfer, filled by wait_done.
   int            mon_lat, mon_first_sel_tick, mon_access_ticks;
   logic [NS-1:0] mon_sel;
   logic [AW-1:0] mon_paddr;
   logic [DW-1:0] mon_pwdata, mon_hrdata;
   logic          mon_pwrite, mon_stable, mon_setup_ok, mon_hresp, mon_prev_hresp;

   task automatic tick();
      @(negedge hclk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      bus_if.valid    = 1'b1;
      bus_if.hreadyin = 1'b1;
      bus_if.hwrite   = wr;
      bus_if.haddr    = a;
      bus_if.hwdata   = wd;
   endtask

   // Returns at the first cycle with hreadyout=1 after acceptance (or after budget cycles).
   task automatic wait_done(input int budget);
      mon_lat = -1; mon_first_sel_tick = -1; mon_access_ticks = 0; mon_sel = '0;
      mon_stable = 1'b1; mon_setup_ok = 1'b0; mon_prev_hresp = 1'b0; mon_hresp = 1'b0;
      mon_hrdata = '0; mon_paddr = '0; mon_pwdata = '0; mon_pwrite = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (k == 1) bus_if.valid = 1'b0;
         if (bus_if.psel != '0) begin
            if (mon_first_sel_tick < 0) begin
               mon_first_sel_tick = k;
               mon_sel = bus_if.psel; mon_paddr = bus_if.paddr;
               mon_pwdata = bus_if.pwdata; mon_pwrite = bus_if.pwrite;
               mon_setup_ok = !bus_if.penable;
            end else if (bus_if.psel !== mon_sel || bus_if.paddr !== mon_paddr ||
                         bus_if.pwdata !== mon_pwdata || bus_if.pwrite !== mon_pwrite) begin
               mon_stable = 1'b0;
            end
            if (bus_if.penable) mon_access_ticks++;
         end
         if (bus_if.hreadyout) begin
            mon_lat = k; mon_hresp = bus_if.hresp; mon_hrdata = bus_if.hrdata;
            break;
         end
         mon_prev_hresp = bus_if.hresp;
      end
   endtask

   // Reference decode: tag byte arithmetic, -1 when unmapped.
   function automatic int model_slave(input logic [AW-1:0] a);
      int t;
      t = int'(a[AW-1:AW-8]);
      if (t >= int'(BASE) && t < int'(BASE) + NS) return t - int'(BASE);
      return -1;
   endfunction

   task automatic test_reset();
      hreset = 1'b1; bus_if.valid = 1'b0; bus_if.hreadyin = 1'b1;
      tick(); tick();
      checks++;
      if ({bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.hresp, bus_if.hreadyout} !==
          {3'b000, 4'b0001}) begin
         errors++;
         $display("FAIL reset_ctrl: got psel/penable/pwrite/hresp/hreadyout=%b, expected %b",
                  {bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.hresp, bus_if.hreadyout},
                  7'b0000001);
      end
      checks++;
      if (bus_if.paddr !== '0 || bus_if.pwdata !== '0 || bus_if.hrdata !== '0) begin
         errors++;
         $display("FAIL reset_data: got paddr=%h pwdata=%h hrdata=%h, expected all 0",
                  bus_if.paddr, bus_if.pwdata, bus_if.hrdata);
      end
      hreset = 1'b0;
      // A request with hreadyin low must be ignored.
      issue(1'b0, 32'h8100_0000, '0);
      bus_if.hreadyin = 1'b0;
      tick(); tick();
      checks++;
      if (bus_if.psel !== '0 || bus_if.hresp !== 1'b0 || bus_if.hreadyout !== 1'b1) begin
         errors++;
         $display("FAIL hreadyin_low: got psel=%b hresp=%b hreadyout=%b, expected 000 0 1",
                  bus_if.psel, bus_if.hresp, bus_if.hreadyout);
      end
      bus_if.valid = 1'b0; bus_if.hreadyin = 1'b1;
   endtask

   task automatic test_write();
      slv_waits = 0; slv_err = 1'b0;
      issue(1'b1, 32'h8200_0000, 32'd45);
      wait_done(50);
      checks++;
      if (mon_lat !== 3 || mon_first_sel_tick !== 2) begin
         errors++;
         $display("FAIL write_latency: got done=%0d setup=%0d, expected done=3 setup=2",
                  mon_lat, mon_first_sel_tick);
      end
      checks++;
      if (mon_sel !== 3'b010 || mon_pwdata !== 32'd45 || mon_pwrite !== 1'b1 ||
          mon_paddr !== 32'h8200_0000 || !mon_setup_ok) begin
         errors++;
         $display("FAIL write_apb: got psel=%b pwdata=%0d pwrite=%b paddr=%h setup=%b, expected 010 45 1 82000000 1",
                  mon_sel, mon_pwdata, mon_pwrite, mon_paddr, mon_setup_ok);
      end
      checks++;
      if (mon_hresp !== 1'b0 || mon_hrdata !== '0) begin
         errors++;
         $display("FAIL write_resp: got hresp=%b hrdata=%h, expected 0 0", mon_hresp, mon_hrdata);
      end
   endtask

   task automatic test_read();
      slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'd543;
      tick();
      issue(1'b0, 32'h8100_0000, '0);
      wait_done(50);
      checks++;
      if (mon_lat !== 2 || mon_sel !== 3'b001 || mon_pwrite !== 1'b0) begin
         errors++;
         $display("FAIL read_basic: got done=%0d psel=%b pwrite=%b, expected 2 001 0",
                  mon_lat, mon_sel, mon_pwrite);
      end
      checks++;
      if (mon_hrdata !== 32'd543 || mon_hresp !== 1'b0) begin
         errors++;
         $display("FAIL read_data: got hrdata=%0d hresp=%b, expected 543 0", mon_hrdata, mon_hresp);
      end
   endtask

   task automatic test_wait_states();
      slv_waits = 3; slv_err = 1'b0; slv_rdata = 32'hdead_beef;
      tick();
      issue(1'b0, 32'h8300_0000, '0);
      wait_done(50);
      checks++;
      if (mon_lat !== 5 || mon_access_ticks !== 4) begin
         errors++;
         $display("FAIL wait_latency: got done=%0d access=%0d, expected 5 4",
                  mon_lat, mon_access_ticks);
      end
      checks++;
      if (!mon_stable || mon_sel !== 3'b100 || mon_paddr !== 32'h8300_0000 ||
          mon_hrdata !== 32'hdead_beef) begin
         errors++;
         $display("FAIL wait_apb: got stable=%b psel=%b paddr=%h hrdata=%h, expected 1 100 83000000 deadbeef",
                  mon_stable, mon_sel, mon_paddr, mon_hrdata);
      end
   endtask

   task automatic test_errors();
      slv_waits = 0; slv_err = 1'b0;
      tick();
      issue(1'b0, 32'h9000_0000, '0);
      wait_done(50);
      checks++;
      if (mon_lat !== 2 || mon_first_sel_tick !== -1 || mon_prev_hresp !== 1'b1 ||
          mon_hresp !== 1'b1) begin
         errors++;
         $display("FAIL unmapped: got done=%0d sel_tick=%0d hresp=%b,%b, expected 2 -1 1,1",
                  mon_lat, mon_first_sel_tick, mon_prev_hresp, mon_hresp);
      end
      tick();
      checks++;
      if (bus_if.hresp !== 1'b0 || bus_if.hreadyout !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_after: got hresp=%b hreadyout=%b, expected 0 1",
                  bus_if.hresp, bus_if.hreadyout);
      end
      slv_waits = 1; slv_err = 1'b1;
      issue(1'b1, 32'h8100_0000, 32'h1234);
      wait_done(50);
      checks++;
      if (mon_lat !== 6 || mon_sel !== 3'b001 || mon_prev_hresp !== 1'b1 || mon_hresp !== 1'b1) begin
         errors++;
         $display("FAIL slverr: got done=%0d psel=%b hresp=%b,%b, expected 6 001 1,1",
                  mon_lat, mon_sel, mon_prev_hresp, mon_hresp);
      end
      tick();
      checks++;
      if (bus_if.hresp !== 1'b0) begin
         errors++;
         $display("FAIL slverr_after: got hresp=%b, expected 0", bus_if.hresp);
      end
      slv_err = 1'b0; slv_waits = 0;
   endtask

   task automatic test_back_to_back();
      slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'h0bad_cafe;
      issue(1'b1, 32'h8100_0000, 32'h5555_aaaa);
      wait_done(50);
      issue(1'b0, 32'h8300_0000, '0);
      wait_done(50);
      checks++;
      if (mon_lat !== 2 || mon_first_sel_tick !== 1 || !mon_setup_ok || mon_sel !== 3'b100 ||
          mon_hrdata !== 32'h0bad_cafe) begin
         errors++;
         $display("FAIL b2b_read: got done=%0d setup_tick=%0d setup=%b psel=%b hrdata=%h, expected 2 1 1 100 0badcafe",
                  mon_lat, mon_first_sel_tick, mon_setup_ok, mon_sel, mon_hrdata);
      end
      // Error response followed immediately by a new read accepted in ERR2.
      issue(1'b0, 32'h8000_0000, '0);
      wait_done(50);
      issue(1'b0, 32'h8200_0000, '0);
      wait_done(50);
      checks++;
      if (mon_lat !== 2 || mon_sel !== 3'b010 || mon_hresp !== 1'b0) begin
         errors++;
         $display("FAIL b2b_after_err: got done=%0d psel=%b hresp=%b, expected 2 010 0",
                  mon_lat, mon_sel, mon_hresp);
      end
   endtask

   task automatic test_reset_mid_access();
      slv_waits = 1000; slv_err = 1'b0;
      tick();
      issue(1'b1, 32'h8200_0040, 32'hfeed_f00d);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) bus_if.valid = 1'b0;
      end
      checks++;
      if (bus_if.penable !== 1'b1 || bus_if.pwdata !== 32'hfeed_f00d) begin
         errors++;
         $display("FAIL stall_access: got penable=%b pwdata=%h, expected 1 feedf00d",
                  bus_if.penable, bus_if.pwdata);
      end
      hreset = 1'b1;
      tick();
      checks++;
      if (bus_if.psel !== '0 || bus_if.penable !== 1'b0 || bus_if.pwrite !== 1'b0 ||
          bus_if.paddr !== '0 || bus_if.pwdata !== '0 || bus_if.hresp !== 1'b0 ||
          bus_if.hreadyout !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h hresp=%b hreadyout=%b, expected reset values",
                  bus_if.psel, bus_if.penable, bus_if.pwrite, bus_if.paddr, bus_if.pwdata,
                  bus_if.hresp, bus_if.hreadyout);
      end
      hreset = 1'b0; slv_waits = 0;
      tick();
      checks++;
      if (bus_if.psel !== '0 || bus_if.hreadyout !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got psel=%b hreadyout=%b, expected 000 1",
                  bus_if.psel, bus_if.hreadyout);
      end
   endtask

   task automatic test_timeout();
      slv_waits = 1000; slv_err = 1'b0;
      issue(1'b0, 32'h8100_0000, '0);
`ifdef APB_TIMEOUT_EN
      wait_done(100);
      checks++;
      if (mon_lat !== 1 + TO + 2 || mon_access_ticks !== TO || mon_prev_hresp !== 1'b1 ||
          mon_hresp !== 1'b1) begin
         errors++;
         $display("FAIL timeout: got done=%0d access=%0d hresp=%b,%b, expected %0d %0d 1,1",
                  mon_lat, mon_access_ticks, mon_prev_hresp, mon_hresp, 1 + TO + 2, TO);
      end
`else
      for (int k = 1; k <= 102; k++) begin
         tick();
         if (k == 1) bus_if.valid = 1'b0;
      end
      checks++;
      if (bus_if.psel !== 3'b001 || bus_if.penable !== 1'b1 || bus_if.hreadyout !== 1'b0 ||
          bus_if.hresp !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: got psel=%b penable=%b hreadyout=%b hresp=%b, expected 001 1 0 0",
                  bus_if.psel, bus_if.penable, bus_if.hreadyout, bus_if.hresp);
      end
      hreset = 1'b1;
      tick();
      hreset = 1'b0;
`endif
      slv_waits = 0;
      tick();
   endtask

   task automatic test_random();
      logic          wr, err, exp_err;
      logic [7:0]    tag;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, rd, exp_rd;
      logic [NS-1:0] exp_sel;
      int            waits, idx, exp_lat, gap;
      for (int n = 0; n < 60; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 7) tag = 8'(int'(BASE) + int'($urandom_range(0, NS - 1)));
         else tag = 8'($urandom);
         a = {tag, 24'($urandom)};
         wd = $urandom; rd = $urandom;
         waits = int'($urandom_range(0, 3));
         err = ($urandom_range(0, 3) == 0);
         idx = model_slave(a);
         exp_err = (idx < 0) || err;
         exp_sel = (idx >= 0) ? NS'(1 << idx) : '0;
         exp_lat = (idx < 0) ? 2 : (wr ? 3 : 2) + waits + (err ? 2 : 0);
         exp_rd  = (idx >= 0 && !wr && !err) ? rd : '0;
         slv_waits = waits; slv_err = err; slv_rdata = rd;
         issue(wr, a, wd);
         wait_done(50);
         checks++;
         if (mon_lat !== exp_lat || mon_sel !== exp_sel) begin
            errors++;
            $display("FAIL rand_timing[%0d]: got done=%0d psel=%b, expected %0d %b (addr=%h wr=%b)",
                     n, mon_lat, mon_sel, exp_lat, exp_sel, a, wr);
         end
         checks++;
         if (mon_hresp !== exp_err || mon_prev_hresp !== exp_err || mon_hrdata !== exp_rd) begin
            errors++;
            $display("FAIL rand_resp[%0d]: got hresp=%b,%b hrdata=%h, expected %b,%b %h",
                     n, mon_prev_hresp, mon_hresp, mon_hrdata, exp_err, exp_err, exp_rd);
         end
         if (idx >= 0) begin
            checks++;
            if (mon_paddr !== a || mon_pwrite !== wr || !mon_stable || !mon_setup_ok ||
                (wr && mon_pwdata !== wd)) begin
               errors++;
               $display("FAIL rand_apb[%0d]: got paddr=%h pwrite=%b pwdata=%h stable=%b setup=%b, expected %h %b %h 1 1",
                        n, mon_paddr, mon_pwrite, mon_pwdata, mon_stable, mon_setup_ok, a, wr, wd);
            end
         end
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) tick();
      end
   endtask

   initial begin
      hreset = 1'b1;
      bus_if.valid = 1'b0; bus_if.hreadyin = 1'b1; bus_if.hwrite = 1'b0;
      bus_if.haddr = '0; bus_if.hwdata = '0;
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_errors();
      test_back_to_back();
      test_reset_mid_access();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no summary by time limit, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
